// File: rtl/calc_seq.sv
// calc_seq: queued accumulator program sequencer (NOP/ADD/SUB/MUL/DIV/LOAD/CLR/POW); CALC_SEQ_SAT_EN selects saturating overflow.
// Latency: 1-cycle ops; DIV = 1+WIDTH cycles; POW n = 1+n cycles; done pulses 2 cycles after the last op completes.
// Backpressure: cmd_ready drops while the queue is full or a program is running; refused commands are never written.

module calc_seq_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             doPush;
    logic             doPop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full && !flush;
    assign doPop    = pop && !empty && !flush;
    assign headData = mem[rdPtr];

    // storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // wrapping pointers and occupancy; flush discards everything still queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= wrPtr;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module calc_seq #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    input  logic             run,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       error
);
`ifdef CALC_SEQ_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_LOAD = 4'b0101;
    localparam logic [3:0] OP_CLR  = 4'b1100;
    localparam logic [3:0] OP_POW  = 4'b1111;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_DIV0 = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        DIVIDE,
        POWER,
        FINISH
    } stateT;

    stateT            state, stateNext;
    logic [WIDTH-1:0] acc, accNext;
    logic [1:0]       err, errNext;
    logic [3:0]       curOp, curOpNext;
    logic [WIDTH-1:0] curArg, curArgNext;
    // work: quotient during DIV, running product during POW
    logic [WIDTH-1:0] work, workNext;
    // aux: divisor during DIV, base during POW
    logic [WIDTH-1:0] aux, auxNext;
    logic [WIDTH-1:0] rem, remNext;
    logic [WIDTH-1:0] iterCnt, iterNext;
    logic             workOvf, workOvfNext;

    logic             qPush;
    logic             qPop;
    logic             qFlush;
    logic [WIDTH+3:0] qHead;
    logic             qFull;
    logic             qEmpty;

    logic             advance;
    logic             ovfHit;

    logic [WIDTH:0]     addSum;
    logic [WIDTH:0]     subDiff;
    logic [2*WIDTH-1:0] mulProd;
    logic [2*WIDTH-1:0] powProd;
    logic               mulHigh;
    logic               powHigh;
    logic [WIDTH:0]     divShift;
    logic               divFits;

    assign busy      = (state != IDLE) && (state != FINISH);
    assign done      = (state == FINISH);
    assign result    = acc;
    assign error     = err;
    assign cmd_ready = !qFull && !busy;
    assign qPush     = cmd_valid && cmd_ready;

    calc_seq_fifo #(
        .WIDTH (WIDTH + 4),
        .DEPTH (DEPTH)
    ) cmdQueue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (qPush),
        .pushData ({cmd_op, cmd_operand}),
        .pop      (qPop),
        .flush    (qFlush),
        .headData (qHead),
        .full     (qFull),
        .empty    (qEmpty)
    );

    // arithmetic shared by the op states; carry/borrow live in the extra top bit
    assign addSum   = {1'b0, acc} + {1'b0, curArg};
    assign subDiff  = {1'b0, acc} - {1'b0, curArg};
    assign mulProd  = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, curArg};
    assign powProd  = {{WIDTH{1'b0}}, work} * {{WIDTH{1'b0}}, aux};
    assign mulHigh  = |mulProd[2*WIDTH-1:WIDTH];
    assign powHigh  = |powProd[2*WIDTH-1:WIDTH];
    assign divShift = {rem, work[WIDTH-1]};
    assign divFits  = (divShift >= {1'b0, aux});

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            err     <= ERR_NONE;
            curOp   <= OP_NOP;
            curArg  <= '0;
            work    <= '0;
            aux     <= '0;
            rem     <= '0;
            iterCnt <= '0;
            workOvf <= 1'b0;
        end else begin
            state   <= stateNext;
            acc     <= accNext;
            err     <= errNext;
            curOp   <= curOpNext;
            curArg  <= curArgNext;
            work    <= workNext;
            aux     <= auxNext;
            rem     <= remNext;
            iterCnt <= iterNext;
            workOvf <= workOvfNext;
        end
    end

    // next-state, op execution and queue control
    always_comb begin
        stateNext   = state;
        accNext     = acc;
        errNext     = err;
        curOpNext   = curOp;
        curArgNext  = curArg;
        workNext    = work;
        auxNext     = aux;
        remNext     = rem;
        iterNext    = iterCnt;
        workOvfNext = workOvf;
        qPop        = 1'b0;
        qFlush      = 1'b0;
        advance     = 1'b0;
        ovfHit      = 1'b0;

        case (state)
            IDLE: begin
                if (run) begin
                    stateNext = FETCH;
                    errNext   = ERR_NONE;
                end
            end

            FETCH: begin
                advance = 1'b1;
            end

            EXEC: begin
                case (curOp)
                    OP_NOP: begin
                        advance = 1'b1;
                    end
                    OP_ADD: begin
                        accNext = (addSum[WIDTH] && SAT_EN) ? ALL_ONES : addSum[WIDTH-1:0];
                        ovfHit  = addSum[WIDTH];
                        advance = 1'b1;
                    end
                    OP_SUB: begin
                        accNext = (subDiff[WIDTH] && SAT_EN) ? '0 : subDiff[WIDTH-1:0];
                        ovfHit  = subDiff[WIDTH];
                        advance = 1'b1;
                    end
                    OP_MUL: begin
                        accNext = (mulHigh && SAT_EN) ? ALL_ONES : mulProd[WIDTH-1:0];
                        ovfHit  = mulHigh;
                        advance = 1'b1;
                    end
                    OP_LOAD: begin
                        accNext = curArg;
                        advance = 1'b1;
                    end
                    OP_CLR: begin
                        accNext = '0;
                        advance = 1'b1;
                    end
                    OP_DIV: begin
                        if (curArg == '0) begin
                            errNext   = ERR_DIV0;
                            qFlush    = 1'b1;
                            stateNext = FINISH;
                        end else begin
                            workNext  = acc;
                            auxNext   = curArg;
                            remNext   = '0;
                            iterNext  = WIDTH'(WIDTH);
                            stateNext = DIVIDE;
                        end
                    end
                    OP_POW: begin
                        if (curArg == '0) begin
                            accNext = WIDTH'(1);
                            advance = 1'b1;
                        end else begin
                            workNext    = WIDTH'(1);
                            auxNext     = acc;
                            iterNext    = curArg;
                            workOvfNext = 1'b0;
                            stateNext   = POWER;
                        end
                    end
                    default: begin
                        errNext   = ERR_ILL;
                        qFlush    = 1'b1;
                        stateNext = FINISH;
                    end
                endcase
            end

            DIVIDE: begin
                // one restoring step per cycle: shift in the next dividend bit, subtract if it fits
                remNext  = divFits ? (divShift[WIDTH-1:0] - aux) : divShift[WIDTH-1:0];
                workNext = {work[WIDTH-2:0], divFits};
                iterNext = iterCnt - WIDTH'(1);
                if (iterCnt == WIDTH'(1)) begin
                    accNext = {work[WIDTH-2:0], divFits};
                    advance = 1'b1;
                end
            end

            POWER: begin
                // in wrap mode later multiplies keep working on the truncated product
                workNext    = powProd[WIDTH-1:0];
                workOvfNext = workOvf | powHigh;
                iterNext    = iterCnt - WIDTH'(1);
                if (iterCnt == WIDTH'(1)) begin
                    accNext = (workOvfNext && SAT_EN) ? ALL_ONES : powProd[WIDTH-1:0];
                    ovfHit  = workOvfNext;
                    advance = 1'b1;
                end
            end

            FINISH: begin
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        // overflow never masks a divide-by-zero or illegal-opcode code
        if (ovfHit && (errNext == ERR_NONE)) begin
            errNext = ERR_OVF;
        end

        // finishing an op fetches the next head in the same cycle; FETCH is only
        // revisited once the queue has drained, and from there the program ends
        if (advance) begin
            if (!qEmpty) begin
                qPop       = 1'b1;
                curOpNext  = qHead[WIDTH+3:WIDTH];
                curArgNext = qHead[WIDTH-1:0];
                stateNext  = EXEC;
            end else if (state == FETCH) begin
                stateNext = FINISH;
            end else begin
                stateNext = FETCH;
            end
        end
    end
endmodule
